// File: rtl/tc0480scp_rom_arbiter.sv
// tc0480scp_rom_arbiter: round-robin share of one toggle-handshake tile-ROM port among NUM_REQ layer fetchers.
// Latency: ROM grant on the edge a request is seen pending; load/ack on the edge the ROM ack is seen; blank tiles take one edge.
// Backpressure: one ROM transfer outstanding at a time; WAIT stalls with no timeout; requesters hold until ack_toggle matches.
// Ports: i_req_toggle/i_req_addr/i_req_blank in, o_ack_toggle/o_load/o_load_data out (requester side);
//        o_rom_address/o_rom_req out, i_rom_ack/i_rom_data in (ROM side); o_grant_idx, o_busy status.
module tc0480scp_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 64,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [NUM_REQ-1:0]        i_req_toggle,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ-1:0]        i_req_blank,
  output logic [NUM_REQ-1:0]        o_ack_toggle,
  output logic [NUM_REQ-1:0]        o_load,
  output logic [DATA_W-1:0]         o_load_data,
  output logic [IDX_W-1:0]          o_grant_idx,
  output logic                      o_busy,
  output logic [ADDR_W-1:0]         o_rom_address,
  output logic                      o_rom_req,
  input  logic                      i_rom_ack,
  input  logic [DATA_W-1:0]         i_rom_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rst;          // first cycle after reset release: decide DRAIN vs IDLE
  logic [NUM_REQ-1:0]  r_ack;
  logic [NUM_REQ-1:0]  r_load;
  logic [DATA_W-1:0]   r_load_data;
  logic [IDX_W-1:0]    r_grant;
  logic [IDX_W-1:0]    r_rr;
  logic [IDX_W-1:0]    r_g;
  logic [ADDR_W-1:0]   r_rom_address;
  logic                r_rom_req;

  logic [NUM_REQ-1:0]  w_pending;
  logic                w_found;
  logic [IDX_W-1:0]    w_gidx;
  logic [NUM_REQ-1:0]  w_gmask;
  logic [NUM_REQ-1:0]  w_rmask;
  logic                w_rom_done;
  logic                w_serve_blank;
  logic                w_issue;
  logic                w_complete;

  function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] g);
    if (int'(g) == NUM_REQ - 1) return '0;
    return g + 1'b1;
  endfunction

  assign w_pending  = i_req_toggle ^ r_ack;
  assign w_rom_done = (r_rom_req == i_rom_ack);
  assign w_gmask    = NUM_REQ'(1) << w_gidx;
  assign w_rmask    = NUM_REQ'(1) << r_g;

  // Rotating search starting at r_rr; first pending index wins.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && w_pending[IDX_W'((int'(r_rr) + j) % NUM_REQ)]) begin
        w_found = 1'b1;
        w_gidx  = IDX_W'((int'(r_rr) + j) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_rst   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_rst   <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_serve_blank = 1'b0;
    w_issue       = 1'b0;
    w_complete    = 1'b0;
    if (!i_reset_n) begin
      w_state_nxt = ST_IDLE;
    end else if (r_rst) begin
      // A transfer left in flight by a reset must be absorbed, never delivered.
      w_state_nxt = w_rom_done ? ST_IDLE : ST_DRAIN;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            if (i_req_blank[w_gidx]) begin
              w_serve_blank = 1'b1;
            end else begin
              w_issue     = 1'b1;
              w_state_nxt = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (w_rom_done) begin
            w_complete  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (w_rom_done) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_ack         <= '0;
      r_load        <= '0;
      r_load_data   <= '0;
      r_grant       <= '0;
      r_rr          <= '0;
      r_g           <= '0;
      r_rom_address <= '0;
    end else begin
      r_load <= '0;
      if (w_serve_blank) begin
        r_ack       <= r_ack ^ w_gmask;
        r_load      <= w_gmask;
        r_load_data <= '0;
        r_grant     <= w_gidx;
        r_rr        <= f_next(w_gidx);
      end
      if (w_issue) begin
        r_rom_address <= i_req_addr[int'(w_gidx)*ADDR_W +: ADDR_W];
        r_grant       <= w_gidx;
        r_g           <= w_gidx;
      end
      if (w_complete) begin
        r_ack       <= r_ack ^ w_rmask;
        r_load      <= w_rmask;
        r_load_data <= i_rom_data;
        r_rr        <= f_next(r_g);
      end
    end
  end

  // The ROM request toggle keeps parity with the ROM controller across our reset.
  always_ff @(posedge i_clk) begin
    if (w_issue) r_rom_req <= ~r_rom_req;
  end

  assign o_ack_toggle  = r_ack;
  assign o_load        = r_load;
  assign o_load_data   = r_load_data;
  assign o_grant_idx   = r_grant;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_rom_address = r_rom_address;
  assign o_rom_req     = r_rom_req;

endmodule

// File: tb/tb_tc0480scp_rom_arbiter.sv
// Bench for tc0480scp_rom_arbiter: directed table of arbitration orders, hand sequences for reset/drain,
// starvation and slow ROM, then random traffic against a transaction-level reference model.
module tb_tc0480scp_rom_arbiter;
  localparam int N  = 4;
  localparam int AW = 23;
  localparam int DW = 64;

  logic              i_clk = 1'b0;
  logic              i_reset_n = 1'b0;
  logic [N-1:0]      i_req_toggle = '0;
  logic [N*AW-1:0]   i_req_addr = '0;
  logic [N-1:0]      i_req_blank = '0;
  logic [N-1:0]      o_ack_toggle;
  logic [N-1:0]      o_load;
  logic [DW-1:0]     o_load_data;
  logic [1:0]        o_grant_idx;
  logic              o_busy;
  logic [AW-1:0]     o_rom_address;
  logic              o_rom_req;
  logic              i_rom_ack = 1'b0;
  logic [DW-1:0]     i_rom_data = '0;

  tc0480scp_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_req_toggle(i_req_toggle),
    .i_req_addr(i_req_addr), .i_req_blank(i_req_blank), .o_ack_toggle(o_ack_toggle),
    .o_load(o_load), .o_load_data(o_load_data), .o_grant_idx(o_grant_idx),
    .o_busy(o_busy), .o_rom_address(o_rom_address), .o_rom_req(o_rom_req),
    .i_rom_ack(i_rom_ack), .i_rom_data(i_rom_data)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: outstanding requests, rotating pointer, one in-flight ROM transaction.
  logic [N-1:0]  m_ack = '0;
  int            m_rr = 0;
  logic [1:0]    m_grant = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int            m_inflight = -1;
  bit            m_drain = 1'b0;
  bit            m_first = 1'b1;
  bit            busy_exp = 1'b0;

  // ROM environment
  bit            rom_busy = 1'b0;
  int            rom_cnt = 0;
  int            rom_delay = 3;
  bit            force_data = 1'b0;
  logic [DW-1:0] rom_next_data = '0;
  logic          last_rom_req = 1'b0;
  bit            flip_seen = 1'b0;
  int            svc_log[$];

  typedef struct {
    int         pre;
    logic [3:0] pend;
    logic [3:0] blank;
    logic [15:0] ord;
    int         n;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_edge(output logic [N-1:0] exp_load, output bit exp_issue);
    logic [N-1:0] pend;
    int g;
    exp_load  = '0;
    exp_issue = 1'b0;
    if (!i_reset_n) begin
      m_ack = '0; m_rr = 0; m_grant = '0; m_addr = '0; m_data = '0;
      m_inflight = -1; m_drain = 1'b0; m_first = 1'b1;
    end else if (m_first) begin
      m_first = 1'b0;
      m_drain = rom_busy;
    end else if (m_drain) begin
      if (!rom_busy) m_drain = 1'b0;
    end else if (m_inflight >= 0) begin
      if (!rom_busy) begin
        exp_load   = N'(1) << m_inflight;
        m_data     = i_rom_data;
        m_ack      = m_ack ^ exp_load;
        m_rr       = (m_inflight + 1) % N;
        m_inflight = -1;
      end
    end else begin
      pend = i_req_toggle ^ m_ack;
      g = -1;
      for (int j = 0; j < N; j++) begin
        if (g < 0 && pend[(m_rr + j) % N]) g = (m_rr + j) % N;
      end
      if (g >= 0) begin
        m_grant = 2'(g);
        svc_log.push_back(g);
        if (i_req_blank[g]) begin
          exp_load = N'(1) << g;
          m_data   = '0;
          m_ack    = m_ack ^ exp_load;
          m_rr     = (g + 1) % N;
        end else begin
          exp_issue  = 1'b1;
          m_inflight = g;
          m_addr     = i_req_addr[g*AW +: AW];
        end
      end
    end
    busy_exp = (m_inflight >= 0) || m_drain;
  endtask

  task automatic tick();
    logic [N-1:0] exp_load;
    bit exp_issue;
    @(posedge i_clk);
    #1;
    model_edge(exp_load, exp_issue);
    flip_seen    = (o_rom_req != last_rom_req);
    last_rom_req = o_rom_req;
    chk("load", 64'(o_load), 64'(exp_load));
    chk("load_data", o_load_data, m_data);
    chk("ack_toggle", 64'(o_ack_toggle), 64'(m_ack));
    chk("grant_idx", 64'(o_grant_idx), 64'(m_grant));
    chk("busy", 64'(o_busy), 64'(busy_exp));
    chk("rom_address", 64'(o_rom_address), 64'(m_addr));
    chk("rom_req_flip", 64'(flip_seen), 64'(exp_issue));
    if (rom_busy) begin
      rom_cnt--;
      if (rom_cnt <= 0) begin
        i_rom_ack  = ~i_rom_ack;
        i_rom_data = rom_next_data;
        rom_busy   = 1'b0;
      end
    end else if (flip_seen) begin
      rom_busy   = 1'b1;
      rom_cnt    = rom_delay;
      i_rom_data = {$urandom, $urandom};
      if (!force_data) rom_next_data = {$urandom, $urandom};
    end
  endtask

  task automatic req(input int i, input logic blank, input logic [AW-1:0] addr);
    i_req_blank[i]          = blank;
    i_req_addr[i*AW +: AW]  = addr;
    i_req_toggle[i]         = ~i_req_toggle[i];
  endtask

  task automatic wait_idle();
    int b = 0;
    while (((i_req_toggle ^ m_ack) != '0 || m_inflight >= 0 || m_drain || rom_busy) && b < 1000) begin
      tick();
      b++;
    end
    chk("wait_idle_in_budget", 64'(b < 1000), 64'd1);
  endtask

  initial begin
    vec_t tbl[5];
    int lat;
    int pos;
    int b;
    int rel;
    int loads;
    int viol;
    bit busy_hi;
    bit found3;
    logic [N-1:0] pend;
    logic [AW-1:0] a0;
    logic [N-1:0] k0;
    int exp_i;

    tbl[0] = '{pre: 3, pend: 4'hF, blank: 4'h0, ord: 16'h0123, n: 4};
    tbl[1] = '{pre: 1, pend: 4'hF, blank: 4'h0, ord: 16'h2301, n: 4};
    tbl[2] = '{pre: 3, pend: 4'hF, blank: 4'hA, ord: 16'h0123, n: 4};
    tbl[3] = '{pre: 0, pend: 4'h9, blank: 4'h0, ord: 16'h0030, n: 2};
    tbl[4] = '{pre: 2, pend: 4'h6, blank: 4'h4, ord: 16'h0012, n: 2};

    #1;
    i_rom_ack    = o_rom_req;
    last_rom_req = o_rom_req;
    repeat (3) tick();
    chk("reset_busy", 64'(o_busy), 64'd0);
    chk("reset_ack", 64'(o_ack_toggle), 64'd0);
    chk("reset_load", 64'(o_load), 64'd0);
    i_reset_n = 1'b1;
    tick();

    // Single ROM fetch for requester 2
    force_data    = 1'b1;
    rom_next_data = 64'hDEADBEEF_01234567;
    rom_delay     = 5;
    req(2, 1'b0, 23'h012340);
    tick();
    chk("t1_issue_flip", 64'(flip_seen), 64'd1);
    chk("t1_addr", 64'(o_rom_address), 64'h012340);
    lat = 0;
    while (o_load == '0 && lat < 20) begin
      tick();
      lat++;
    end
    chk("t1_latency", 64'(lat), 64'd6);
    chk("t1_load", 64'(o_load), 64'b0100);
    chk("t1_data", o_load_data, 64'hDEADBEEF_01234567);
    chk("t1_ack2", 64'(o_ack_toggle[2]), 64'd1);
    tick();
    chk("t1_load_pulse_end", 64'(o_load), 64'd0);
    force_data = 1'b0;

    // Table of arbitration orders
    for (int r = 0; r < 5; r++) begin
      rom_delay = 2;
      if (tbl[r].pre >= 0) begin
        req(tbl[r].pre, 1'b0, AW'($urandom));
        wait_idle();
      end
      svc_log.delete();
      for (int i = 0; i < N; i++) begin
        if (tbl[r].pend[i]) req(i, tbl[r].blank[i], AW'($urandom));
      end
      wait_idle();
      chk($sformatf("tbl%0d_count", r), 64'(svc_log.size()), 64'(tbl[r].n));
      for (int i = 0; i < tbl[r].n; i++) begin
        exp_i = int'((tbl[r].ord >> (4 * (tbl[r].n - 1 - i))) & 16'hF);
        chk($sformatf("tbl%0d_order%0d", r, i),
            64'(i < svc_log.size() ? svc_log[i] : -1), 64'(exp_i));
      end
    end

    // Starvation: requester 0 re-requests as soon as it is acked while 3 waits
    svc_log.delete();
    rom_delay = 1;
    req(3, 1'b0, AW'($urandom));
    req(0, 1'b0, AW'($urandom));
    found3 = 1'b0;
    b = 0;
    while (!found3 && b < 200) begin
      tick();
      b++;
      foreach (svc_log[q]) if (svc_log[q] == 3) found3 = 1'b1;
      pend = i_req_toggle ^ m_ack;
      if (!found3 && !pend[0]) req(0, 1'b0, AW'($urandom));
    end
    pos = -1;
    foreach (svc_log[q]) if (pos < 0 && svc_log[q] == 3) pos = q;
    chk("starve_found", 64'(found3), 64'd1);
    chk("starve_within4", 64'(pos >= 0 && pos < 4), 64'd1);
    wait_idle();

    // Reset while WAIT; ROM ack lands 4 cycles after release
    rom_delay = 9;
    req(1, 1'b0, 23'h0ABCDE);
    tick();
    chk("rst_issue_flip", 64'(flip_seen), 64'd1);
    tick();
    tick();
    i_reset_n    = 1'b0;
    i_req_toggle = '0;
    repeat (3) tick();
    chk("rst_busy_low", 64'(o_busy), 64'd0);
    i_reset_n = 1'b1;
    rel = 0; loads = 0; busy_hi = 1'b0;
    rom_delay = 3;
    tick(); rel++;
    chk("drain_busy", 64'(o_busy), 64'd1);
    tick(); rel++;
    req(1, 1'b0, 23'h055555);
    while (!flip_seen && rel < 40) begin
      if (o_busy) busy_hi = 1'b1;
      if (o_load != '0) loads++;
      tick(); rel++;
    end
    chk("drain_no_load", 64'(loads), 64'd0);
    chk("drain_busy_seen", 64'(busy_hi), 64'd1);
    chk("reissue_edge", 64'(rel), 64'd6);
    chk("reissue_addr", 64'(o_rom_address), 64'h055555);
    wait_idle();

    // Slow ROM: 200-cycle ack
    rom_delay = 200;
    req(0, 1'b0, 23'h7F00AA);
    tick();
    chk("slow_issue_flip", 64'(flip_seen), 64'd1);
    a0 = o_rom_address;
    k0 = o_ack_toggle;
    chk("slow_addr", 64'(a0), 64'h7F00AA);
    viol = 0;
    repeat (199) begin
      tick();
      if (o_rom_address != a0 || o_ack_toggle != k0 || !o_busy || o_load != '0) viol++;
    end
    chk("slow_hold_violations", 64'(viol), 64'd0);
    wait_idle();

    // Random traffic
    svc_log.delete();
    repeat (400) begin
      rom_delay = $urandom_range(1, 6);
      pend = i_req_toggle ^ m_ack;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0)
          req(i, logic'($urandom_range(0, 3) == 0), AW'($urandom));
      end
      tick();
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tc0480scp_rom_arbiter.md
# tc0480scp_rom_arbiter

Shares the single 64-bit tile-ROM port between the four TC0480SCP background-layer fetchers. Requesters use toggle req/ack handshakes, and grants rotate round-robin. Blank tiles (code 0) are answered without touching the ROM. The block sits between the per-layer attribute fetch logic and the SDRAM ROM channel, and replaces ad-hoc fixed-priority request scanning.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 23, ROM word address width
- DATA_W, 64, ROM data width (one 16-pixel 4bpp tile row)

- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- req_toggle  in  NUM_REQ  per-requester request toggle; pending when != ack_toggle[i]
- req_addr  in  NUM_REQ*ADDR_W  per-requester ROM address; slice i at [i*ADDR_W +: ADDR_W]; stable while pending
- req_blank  in  NUM_REQ  per-requester blank-tile flag; stable while pending
- ack_toggle  out  NUM_REQ  per-requester acknowledge toggle
- load  out  NUM_REQ  one-cycle pulse on the requester whose data is on load_data
- load_data  out  DATA_W  fetched row data, or zero for a blank tile
- grant_idx  out  $clog2(NUM_REQ)  index of the last granted requester
- busy  out  1  high while not IDLE
- rom_address  out  ADDR_W  ROM address, registered
- rom_req  out  1  ROM request toggle
- rom_ack  in  1  ROM acknowledge toggle; transfer complete when equal to rom_req
- rom_data  in  DATA_W  ROM data, valid in the cycle rom_ack == rom_req

## Operation
- States: DRAIN, IDLE, WAIT.
- pending[i] = req_toggle[i] ^ ack_toggle[i].
- The round-robin pointer rr holds the index searched first. Search order is rr, rr+1, ... modulo NUM_REQ.
- IDLE with no pending requester: hold state.
- IDLE, first pending index g is blank:
  - ack_toggle[g] flips, load[g]=1, load_data=0, grant_idx=g, rr=g+1.
  - Stay in IDLE. No ROM access.
- IDLE, first pending index g is not blank:
  - rom_address = req_addr[g]; rom_req flips; grant_idx=g; latch g.
  - Go to WAIT.
- WAIT while rom_req != rom_ack: hold state. No timeout.
- WAIT when rom_req == rom_ack:
  - load_data = rom_data; load[g]=1; ack_toggle[g] flips; rr = g+1 (wraps to 0 past NUM_REQ-1).
  - Go to IDLE.
- DRAIN:
  - Wait for rom_req == rom_ack. Then go to IDLE.
  - Data is discarded: no load pulse, no ack change.
- Only one ROM transaction is ever outstanding. A requester toggles again only after its ack matches; otherwise behaviour is undefined.
- Requests that change during WAIT are not sampled until the return to IDLE.

## Timing
- Reset (reset_n low at a clk edge):
  - ack_toggle=0, load=0, load_data=0, grant_idx=0, rr=0, rom_address=0.
  - rom_req is NOT reset; it keeps its parity with the separately reset ROM controller.
- State on the first edge after reset_n is high:
  - DRAIN if rom_req != rom_ack, else IDLE.
  - busy is 0 during reset and 1 in DRAIN.
- Reset while in WAIT: the in-flight transfer is drained, never delivered.
- Request path:
  - Pending visible at edge k: rom_req flips at edge k.
  - ROM completion sampled at edge m: load, load_data and ack_toggle update together at edge m.
  - load is high for exactly the cycle after edge m.
- Back-to-back ROM grants: the next rom_req flip is at edge m+1 at the earliest, i.e. one IDLE cycle.
- Blank grants complete in one cycle each. Consecutive blank requesters are served on consecutive edges, one per edge.
- load is one-hot or zero. Only one requester is serviced per edge.

## Test plan
- After reset with rom_req==rom_ack, req_toggle[2] flips with addr 0x012340, blank=0:
  - rom_req flips next edge with rom_address=0x012340.
  - Model acks after 5 cycles with data 0xDEADBEEF_01234567.
  - load=4'b0100 for one cycle with that data, and ack_toggle[2] flips the same edge.
- All four requesters flip simultaneously, none blank, rr=0:
  - Grant order is 0,1,2,3, and grant_idx matches each.
  - Repeat with rr=2 (after a grant to 1): order is 2,3,0,1.
- Requesters 1 and 3 are blank, 0 and 2 not, all pending:
  - Sequence: ROM for 0, then blank 1 (load_data=0, no rom_req flip), then ROM for 2, then blank 3.
- Assert reset_n low for 3 cycles while in WAIT, with the ROM ack arriving 4 cycles after release:
  - busy=1 in DRAIN and no load pulse.
  - A pending request issued after release gets a fresh rom_req flip only after the drain completes.
- Starvation: requester 0 re-toggles immediately after every ack while 3 is pending. Requester 3 is granted within 4 grants.
- Slow ROM (ack after 200 cycles): state holds WAIT with rom_address stable and no ack_toggle changes in the interim.
